// File: rtl/wb_pkg.sv
// Shared Wishbone bus widths and the arbiter FSM state type.
package wb_pkg;

    localparam int WB_AW   = 64;
    localparam int WB_DW   = 64;
    localparam int WB_SELW = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } wb_arb_state_e;

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of all master-side and slave-side Wishbone signals around the arbiter.
interface wb_rr_arbiter_if
    import wb_pkg::*;
#(
    parameter int N = 4
);
    logic [N-1:0]         m_cyc_i, m_stb_i, m_we_i, m_lock_i;
    logic [N*WB_AW-1:0]   m_adr_i;
    logic [N*WB_DW-1:0]   m_dat_i;
    logic [N*WB_SELW-1:0] m_sel_i;
    logic [WB_DW-1:0]     m_dat_o;
    logic [N-1:0]         m_ack_o, m_err_o, m_rty_o;

    logic                 s_cyc_o, s_stb_o, s_we_o, s_lock_o;
    logic [WB_AW-1:0]     s_adr_o;
    logic [WB_DW-1:0]     s_dat_o;
    logic [WB_SELW-1:0]   s_sel_o;
    logic [WB_DW-1:0]     s_dat_i;
    logic                 s_ack_i, s_err_i, s_rty_i;

    logic [N-1:0]         gnt_o;

    // Arbiter's view of the bus.
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_lock_i, m_adr_i, m_dat_i, m_sel_i,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_adr_o, s_dat_o, s_sel_o,
        output gnt_o
    );

    // Environment's view: the masters and the slave around the arbiter.
    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_lock_i, m_adr_i, m_dat_i, m_sel_i,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_adr_o, s_dat_o, s_sel_o,
        input  gnt_o
    );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: lowest requester strictly above `last`, else lowest overall.
module wb_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    output logic [N-1:0] gnt
);
    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] above, req_hi;

    // x & (~x + 1) isolates the lowest set bit of x.
    assign above  = ~(last | (last - ONE));
    assign req_hi = req & above;
    assign gnt    = (|req_hi) ? (req_hi & (~req_hi + ONE)) : (req & (~req + ONE));

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter granting whole bus cycles from N masters to one slave.
// Define WB_ARB_WATCHDOG_EN to build the stalled-slave watchdog (limit TIMEOUT cycles).
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input logic            clk,
    input logic            rst,
    wb_rr_arbiter_if.slave bus
);
    localparam logic [N-1:0] LAST_RST = {1'b1, {(N-1){1'b0}}};

    wb_arb_state_e      state;
    logic [N-1:0]       gnt, last, pick;
    logic               own_cyc, own_stb, own_lock, term, wd_fire;
    logic [WB_AW-1:0]   mux_adr;
    logic [WB_DW-1:0]   mux_dat;
    logic [WB_SELW-1:0] mux_sel;

    wb_rr_pick #(.N(N)) u_pick (
        .req  (bus.m_cyc_i),
        .last (last),
        .gnt  (pick)
    );

    assign own_cyc  = |(gnt & bus.m_cyc_i);
    assign own_stb  = |(gnt & bus.m_stb_i);
    assign own_lock = |(gnt & bus.m_lock_i);
    assign term     = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;

`ifdef WB_ARB_WATCHDOG_EN
    localparam int              WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    logic [WD_W-1:0] wd_cnt;

    // A termination in the limit cycle wins over the timeout.
    assign wd_fire = (state == OWNED) && (wd_cnt == WD_LIMIT) && !term;

    always_ff @(posedge clk) begin
        if (rst || state != OWNED || term || wd_fire) wd_cnt <= '0;
        else if (own_stb)                             wd_cnt <= wd_cnt + 1'b1;
    end
`else
    assign wd_fire = 1'b0;
`endif

    // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        mux_adr = '0;
        mux_dat = '0;
        mux_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                mux_adr = mux_adr | bus.m_adr_i[i*WB_AW +: WB_AW];
                mux_dat = mux_dat | bus.m_dat_i[i*WB_DW +: WB_DW];
                mux_sel = mux_sel | bus.m_sel_i[i*WB_SELW +: WB_SELW];
            end
        end
    end

    assign bus.s_cyc_o  = own_cyc & ~wd_fire;
    assign bus.s_stb_o  = own_stb & ~wd_fire;
    assign bus.s_we_o   = |(gnt & bus.m_we_i);
    assign bus.s_lock_o = own_lock;
    assign bus.s_adr_o  = mux_adr;
    assign bus.s_dat_o  = mux_dat;
    assign bus.s_sel_o  = mux_sel;

    // Terminations reach only the owner; with gnt == 0 they are dropped.
    assign bus.m_ack_o = gnt & {N{bus.s_ack_i}};
    assign bus.m_err_o = gnt & {N{bus.s_err_i | wd_fire}};
    assign bus.m_rty_o = gnt & {N{bus.s_rty_i}};
    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.gnt_o   = gnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= LAST_RST;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|bus.m_cyc_i) begin
                        gnt   <= pick;
                        last  <= pick;
                        state <= OWNED;
                    end
                end
                OWNED: begin
                    if (wd_fire || (!own_cyc && !own_lock)) begin
                        gnt   <= '0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone bus arbiter that shares one Wishbone slave port among `N` masters. It sits between the master-side agents or DUT initiators and the single slave interface (64-bit address/data, 8-bit select). It grants whole bus cycles, not single beats. It muxes the owner's request signals to the slave and routes the slave's termination back to the owner only.

## Interface
Parameters:
- `N`, 4: number of masters, 2..8.
- `TIMEOUT`, 255: watchdog limit in cycles (used only when the watchdog is compiled in).

Ports (`[N*w]` denotes per-master vectors packed master 0 at LSBs):
- `clk`  in  1  bus clock. Everything is sampled on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `m_cyc_i`, `m_stb_i`, `m_we_i`, `m_lock_i`  in  N each  per-master control.
- `m_adr_i`  in  N*64  per-master address.
- `m_dat_i`  in  N*64  per-master write data.
- `m_sel_i`  in  N*8  per-master byte selects.
- `m_dat_o`  out  64  read data, broadcast to all masters.
- `m_ack_o`, `m_err_o`, `m_rty_o`  out  N each  per-master terminations.
- `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_lock_o`  out  1 each  slave control.
- `s_adr_o`  out  64  slave address.
- `s_dat_o`  out  64  slave write data.
- `s_sel_o`  out  8  slave byte selects.
- `s_dat_i`  in  64  slave read data.
- `s_ack_i`, `s_err_i`, `s_rty_i`  in  1 each  slave terminations.
- `gnt_o`  out  N  registered one-hot grant, or all zero.

## Operation
- FSM has two states: IDLE and OWNED. The grant register `gnt` and the round-robin pointer `last` are registered. All `s_*` outputs and `m_*_o` outputs are combinational from `gnt` and the inputs.
- IDLE:
  - If any `m_cyc_i` is high, choose the first requesting index after `last`, wrapping modulo N.
  - Set `gnt` to that one-hot index, set `last` to it, and go to OWNED.
  - If no master requests, stay in IDLE with `gnt` = 0.
- OWNED with index g:
  - `s_cyc_o = m_cyc_i[g]`, `s_stb_o = m_stb_i[g]`. `we`, `lock`, `adr`, `dat` and `sel` pass through from master g.
  - `m_ack_o[g] = s_ack_i`, and likewise for `err` and `rty`. All other masters' terminations are 0.
  - Release when `m_cyc_i[g]` = 0 and `m_lock_i[g]` = 0. Next state is IDLE and `gnt` becomes 0.
  - While `m_lock_i[g]` = 1 the grant is held even if `m_cyc_i[g]` drops.
- With `gnt` = 0, every `s_*` control output is 0, `s_adr_o`/`s_dat_o`/`s_sel_o` are 0, and every `m_*_o` termination is 0.
- `m_dat_o = s_dat_i` unconditionally.
- Slave terminations arriving while in IDLE are dropped.
- Reset: state IDLE, `gnt` = 0, `last` = N-1 so master 0 wins first. All outputs are 0 in the cycle after `rst` is sampled high. Reset mid-cycle abandons the transfer with no termination sent to the master.

## Timing
- Arbitration latency: a request sampled in IDLE at edge k gives `gnt_o`, `s_cyc_o` and `s_stb_o` valid after edge k.
- Release costs exactly one IDLE cycle with `s_cyc_o` = 0 between consecutive owners. This is the bus turnaround.
- Termination passthrough is zero-latency (combinational). Masters' classic or pipelined beat timing is unchanged by the arbiter.
- Requests that rise while another master owns the bus wait. No pre-emption.
- If all N masters request continuously, each is granted once per N ownerships.

## Configuration
- `WB_ARB_WATCHDOG_EN` defined:
  - A counter of width `$clog2(TIMEOUT+1)` counts OWNED cycles with `s_stb_o` = 1 and no `s_ack_i`/`s_err_i`/`s_rty_i`. It clears on any termination and on entering OWNED.
  - When the count reaches `TIMEOUT`, assert `m_err_o[g]` for one cycle. In that same cycle force `s_cyc_o` and `s_stb_o` to 0 and go to IDLE, regardless of lock.
  - A slave termination coinciding with the timeout cycle wins, and no timeout fires.
- Undefined: no counter is built and the bus can be held indefinitely.

## Structure
- Shared package `wb_pkg` holds `WB_AW` = 64, `WB_DW` = 64, `WB_SELW` = 8, and the FSM state enum `wb_arb_state_e`.
- The round-robin picker is one natural sub-module, `wb_rr_pick`. It takes a request vector and a last one-hot index and returns a one-hot grant. It is purely combinational.

## Test plan
- Reset, then m0 requests a write to adr `64'h1000` with data `64'hDEAD_BEEF` and sel `8'hFF`, and the slave acks. Required: `gnt_o` = `4'b0001`, the slave sees the same adr/data/sel, `m_ack_o` = `4'b0001` for one cycle, then `gnt_o` = 0.
- m0..m3 all request back-to-back single writes for 8 ownerships. Required grant order: 0,1,2,3,0,1,2,3, with exactly one `s_cyc_o` = 0 cycle between owners.
- m1 is granted with `m_lock_i` = 1 and drops `m_cyc_i` for 2 cycles while m2 requests. Required: `gnt_o` stays `4'b0010` until lock falls, then m2 is granted.
- m2 is granted and the slave returns `s_err_i`, then in a later cycle `s_rty_i`. Required: only `m_err_o[2]`/`m_rty_o[2]` pulse, and `m_ack_o` = 0 throughout.
- `rst` is asserted during an m3 read with STB high. Required: all outputs 0 the next cycle, and m0 is granted first after reset.
- With `WB_ARB_WATCHDOG_EN` and `TIMEOUT` = 16, the slave never terminates. Required: `m_err_o[g]` pulses 16 cycles after STB, then IDLE. Without the macro, the grant is held indefinitely.
